// File: rtl/fft4_bin_serializer_if.sv
// fft4_bin_serializer_if: frame capture handshake and serialized bin stream
interface fft4_bin_serializer_if #(
    parameter int W  = 3,
    parameter int PW = 2 * W
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] rout_0, rout_1, rout_2, rout_3;
    logic signed [W-1:0] iout_0, iout_1, iout_2, iout_3;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_bin;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic [PW-1:0]       out_pwr;
    logic                out_last;
    logic [7:0]          frame_cnt;

    modport master (
        output in_valid, rout_0, rout_1, rout_2, rout_3,
               iout_0, iout_1, iout_2, iout_3, out_ready,
        input  in_ready, out_valid, out_bin, out_re, out_im,
               out_pwr, out_last, frame_cnt
    );

    modport slave (
        input  in_valid, rout_0, rout_1, rout_2, rout_3,
               iout_0, iout_1, iout_2, iout_3, out_ready,
        output in_ready, out_valid, out_bin, out_re, out_im,
               out_pwr, out_last, frame_cnt
    );
endinterface

// File: rtl/fft4_bin_serializer.sv
// fft4_bin_serializer: latches a 4-bin complex frame and streams bins with index and power
module fft4_bin_serializer #(
    parameter int W  = 3,
    parameter int PW = 2 * W
) (
    input logic                 clk,
    input logic                 rst_n,
    fft4_bin_serializer_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_n;
    logic [1:0]          idx;
    logic [7:0]          frame_cnt;
    logic signed [W-1:0] re_q [4];
    logic signed [W-1:0] im_q [4];
    logic signed [W-1:0] re, im;
    logic signed [PW-1:0] re_x, im_x;
    logic                in_ready, out_valid, in_xfer, out_xfer;

    // Handshake decode and next state; a new frame may replace the last bin in the same cycle
    always_comb begin
        state_n   = state;
        out_valid = (state == SEND);
        in_ready  = (state == IDLE) || (idx == 2'd3 && bus.out_ready);
        in_xfer   = bus.in_valid && in_ready;
        out_xfer  = out_valid && bus.out_ready;
        if (state == IDLE && in_xfer)
            state_n = SEND;
        else if (state == SEND && out_xfer && idx == 2'd3 && !in_xfer)
            state_n = IDLE;
    end

    // State, bin index, frame register and completed-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            frame_cnt <= 8'd0;
            for (int k = 0; k < 4; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else begin
            state <= state_n;
            if (in_xfer) begin
                re_q[0] <= bus.rout_0;
                re_q[1] <= bus.rout_1;
                re_q[2] <= bus.rout_2;
                re_q[3] <= bus.rout_3;
                im_q[0] <= bus.iout_0;
                im_q[1] <= bus.iout_1;
                im_q[2] <= bus.iout_2;
                im_q[3] <= bus.iout_3;
                idx     <= 2'd0;
            end else if (out_xfer) begin
                idx <= idx + 2'd1;
            end
            if (out_xfer && idx == 2'd3)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign re   = re_q[idx];
    assign im   = im_q[idx];
    assign re_x = PW'(re);
    assign im_x = PW'(im);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_bin   = idx;
    assign bus.out_re    = re;
    assign bus.out_im    = im;
    assign bus.out_pwr   = re_x * re_x + im_x * im_x;
    assign bus.out_last  = out_valid && idx == 2'd3;
    assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_fft4_bin_serializer.sv
// tb_fft4_bin_serializer: directed vectors for the 4-bin serializer
module tb_fft4_bin_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errs = 0;

    fft4_bin_serializer_if #(.W(3)) bus ();

    fft4_bin_serializer #(.W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_beat(input int b, input int re, input int im, input int pwr, input int last);
        chk("out_valid", 32'(bus.out_valid), 1);
        chk("out_bin", 32'(bus.out_bin), b);
        chk("out_re", 32'(bus.out_re), re);
        chk("out_im", 32'(bus.out_im), im);
        chk("out_pwr", 32'(bus.out_pwr), pwr);
        chk("out_last", 32'(bus.out_last), last);
    endtask

    task automatic set_frame(input int r [4], input int i [4]);
        bus.rout_0 = 3'(r[0]);
        bus.rout_1 = 3'(r[1]);
        bus.rout_2 = 3'(r[2]);
        bus.rout_3 = 3'(r[3]);
        bus.iout_0 = 3'(i[0]);
        bus.iout_1 = 3'(i[1]);
        bus.iout_2 = 3'(i[2]);
        bus.iout_3 = 3'(i[3]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int r [4], input int i [4], input int p [4]);
        set_frame(r, i);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk_beat(b, r[b], i[b], p[b], b == 3 ? 1 : 0);
            chk("in_ready", 32'(bus.in_ready), b == 3 ? 1 : 0);
            tick();
        end
        chk("idle_after_frame", 32'(bus.out_valid), 0);
    endtask

    int fr [3][4] = '{'{2, 0, 2, 0}, '{1, 0, -1, 0}, '{-4, 0, 0, 0}};
    int fi [3][4] = '{'{0, 0, 0, 0}, '{0, -1, 0, 1}, '{-4, 0, 0, 0}};
    int fp [3][4] = '{'{4, 0, 4, 0}, '{1, 1, 1, 1}, '{32, 0, 0, 0}};
    int br [4] = '{1, 2, 3, -1};
    int bi [4] = '{-2, -3, 0, 1};
    int bp [4] = '{5, 13, 9, 2};

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_frame('{0, 0, 0, 0}, '{0, 0, 0, 0});
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_bin", 32'(bus.out_bin), 0);
        chk("rst_out_re", 32'(bus.out_re), 0);
        chk("rst_out_im", 32'(bus.out_im), 0);
        chk("rst_out_pwr", 32'(bus.out_pwr), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Real-only frame, signed frame, then the -4/-4 power corner
        run_frame(fr[0], fi[0], fp[0]);
        chk("frame_cnt_1", 32'(bus.frame_cnt), 1);
        run_frame(fr[1], fi[1], fp[1]);
        chk("frame_cnt_2", 32'(bus.frame_cnt), 2);
        run_frame(fr[2], fi[2], fp[2]);
        chk("frame_cnt_3", 32'(bus.frame_cnt), 3);

        // Backpressure: stall on bin 1 for two cycles, then stall on bin 3
        set_frame(br, bi);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_beat(0, 1, -2, 5, 0);
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk_beat(1, 2, -3, 13, 0);
        chk("bp_in_ready_b1", 32'(bus.in_ready), 0);
        tick();
        chk_beat(1, 2, -3, 13, 0);
        tick();
        chk_beat(1, 2, -3, 13, 0);
        bus.out_ready = 1'b1;
        tick();
        chk_beat(2, 3, 0, 9, 0);
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk_beat(3, -1, 1, 2, 1);
        chk("bp_in_ready_b3_stall", 32'(bus.in_ready), 0);
        tick();
        chk_beat(3, -1, 1, 2, 1);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_b3_go", 32'(bus.in_ready), 1);
        tick();
        chk("bp_idle", 32'(bus.out_valid), 0);
        chk("frame_cnt_4", 32'(bus.frame_cnt), 4);

        // Back-to-back: three frames, 12 beats with no bubble
        set_frame(fr[0], fi[0]);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            if (f < 2) set_frame(fr[f+1], fi[f+1]);
            else bus.in_valid = 1'b0;
            for (int b = 0; b < 4; b++) begin
                chk_beat(b, fr[f][b], fi[f][b], fp[f][b], b == 3 ? 1 : 0);
                chk("b2b_in_ready", 32'(bus.in_ready), b == 3 ? 1 : 0);
                tick();
            end
        end
        chk("b2b_idle", 32'(bus.out_valid), 0);
        chk("frame_cnt_7", 32'(bus.frame_cnt), 7);

        // Asynchronous reset while bin 1 is presented
        set_frame(br, bi);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("pre_rst_bin", 32'(bus.out_bin), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_out_bin", 32'(bus.out_bin), 0);
        chk("arst_out_re", 32'(bus.out_re), 0);
        chk("arst_out_pwr", 32'(bus.out_pwr), 0);
        chk("arst_frame_cnt", 32'(bus.frame_cnt), 0);
        chk("arst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_beat", 32'(bus.out_valid), 0);
        end
        run_frame(fr[0], fi[0], fp[0]);
        chk("frame_cnt_after_rst", 32'(bus.frame_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
